bus_bridge_slave_q: RTL and testbench

- Parametrised successor to the serial-bus bridge slave. Deserialises bit-serial bus writes and reads into {mode, data, addr} frames and queues them in a request FIFO toward the UART transmit side.
- The bus is released after each write, without waiting for the UART. Reads become split transactions: ssplit is held until the remote response returns, then the data is shifted back after split_grant.
- Sits between the bus arbiter/mux and a UART wrapper; connects to the UART through a parallel valid/ready frame interface.

---
 rtl/bus_bridge_pkg.sv | 30 +++
 rtl/bus_bridge_fifo.sv | 63 ++++++
 rtl/bus_bridge_slave_q.sv | 209 ++++++++++++++++++++
 tb/tb_bus_bridge_slave_q.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_bridge_pkg.sv
// rtl/bus_bridge_pkg.sv - shared types and constants for the serial-bus bridge slave
//
// Purpose: FSM state encoding, transaction mode constants and request-frame
//          field offsets used by bus_bridge_slave_q.
// Ports:   none (package).
package bus_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_PUSH  = 3'd3,
    ST_SPLIT = 3'd4,
    ST_GRANT = 3'd5,
    ST_RDATA = 3'd6
  } state_e;

  localparam logic MODE_WRITE = 1'b1;
  localparam logic MODE_READ  = 1'b0;

  // Frame layout is {mode, data, addr}: addr at bit 0, data above it, mode at MSB.
  function automatic int frame_data_lsb(input int addr_width);
    return addr_width;
  endfunction

  function automatic int frame_mode_bit(input int addr_width, input int data_width);
    return addr_width + data_width;
  endfunction

endpackage

// File: rtl/bus_bridge_fifo.sv
// rtl/bus_bridge_fifo.sv - first-word-fall-through request frame FIFO
//
// Purpose: synchronous FWFT queue; the head entry is always visible on rdata_o
//          while the FIFO is not empty.
// Ports:   clk, rst (async, active-high)
//          push_i/wdata_i  - write side; a push while full is discarded
//          pop_i           - removes the head; ignored when empty
//          rdata_o         - head entry
//          count_o         - occupancy, 0..DEPTH
//          full_o, empty_o - occupancy flags
module bus_bridge_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/bus_bridge_slave_q.sv
// rtl/bus_bridge_slave_q.sv - serial-bus bridge slave with queued requests and split reads
//
// Purpose: deserialises bit-serial bus transactions into {mode, data, addr}
//          frames queued toward a UART; reads are completed as split
//          transactions once the remote response arrives.
// Ports:   clk, rst (async, active-high)
//          swdata, smode, mvalid  - serial master side (LSB first)
//          split_grant            - arbiter re-grant for the split read
//          srdata, svalid         - serial read data back to the master
//          sready, ssplit         - slave status toward the bus
//          tx_frame/tx_valid/tx_ready - request frames toward the UART
//          rx_data/rx_valid       - remote read response
//          fifo_count             - request FIFO occupancy
//          rd_timeout             - (BRIDGE_RD_TIMEOUT_EN only) split read timed out
// Option:  define BRIDGE_RD_TIMEOUT_EN to add the RD_TIMEOUT parameter and the
//          rd_timeout output; otherwise SPLIT waits indefinitely.
module bus_bridge_slave_q
  import bus_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int FRAME_WIDTH = ADDR_WIDTH + DATA_WIDTH + 1
`ifdef BRIDGE_RD_TIMEOUT_EN
  ,
  parameter int RD_TIMEOUT  = 100000
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        swdata,
  input  logic                        smode,
  input  logic                        mvalid,
  input  logic                        split_grant,
  output logic                        srdata,
  output logic                        svalid,
  output logic                        sready,
  output logic                        ssplit,
  output logic [FRAME_WIDTH-1:0]      tx_frame,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  input  logic [DATA_WIDTH-1:0]       rx_data,
  input  logic                        rx_valid,
`ifdef BRIDGE_RD_TIMEOUT_EN
  output logic                        rd_timeout,
`endif
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CW       = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_MAX  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W    = $clog2(CNT_MAX);
  localparam int DATA_LSB = frame_data_lsb(ADDR_WIDTH);
  localparam int MODE_BIT = frame_mode_bit(ADDR_WIDTH, DATA_WIDTH);

  state_e                 state_q, state_d;
  logic                   mode_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   sready_q, sready_d;
  logic [CW-1:0]          count_d;
  logic                   push;
  logic                   pop;
  logic                   addr_last;
  logic                   data_last;
  logic                   timeout_hit;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [FRAME_WIDTH-1:0] push_frame;

  assign addr_last = (cnt_q == CNT_W'(ADDR_WIDTH - 1));
  assign data_last = (cnt_q == CNT_W'(DATA_WIDTH - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (mvalid && sready_q) state_d = ST_ADDR;
      ST_ADDR:  if (mvalid && addr_last)
                  state_d = (mode_q == MODE_READ) ? ST_PUSH : ST_WDATA;
      ST_WDATA: if (mvalid && data_last) state_d = ST_PUSH;
      ST_PUSH:  state_d = (mode_q == MODE_WRITE) ? ST_IDLE : ST_SPLIT;
      ST_SPLIT: if (rx_valid || timeout_hit) state_d = ST_GRANT;
      ST_GRANT: if (split_grant) state_d = ST_RDATA;
      ST_RDATA: if (data_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // sready is registered from the next state and next FIFO count so that it
  // is low throughout reset and exactly tracks occupancy once in IDLE.
  always_comb begin
    push     = (state_q == ST_PUSH);
    pop      = tx_valid && tx_ready;
    count_d  = fifo_count + CW'(push) - CW'(pop);
    sready_d = 1'b0;
    case (state_d)
      ST_IDLE:           sready_d = (count_d < CW'(FIFO_DEPTH));
      ST_ADDR, ST_WDATA: sready_d = 1'b1;
      default:           sready_d = 1'b0;
    endcase
    svalid = (state_q == ST_RDATA);
    srdata = svalid && rdata_q[0];
    ssplit = (state_q == ST_SPLIT);
  end

  assign sready = sready_q;

  always_comb begin
    push_frame                                = '0;
    push_frame[ADDR_WIDTH-1:0]                = addr_q;
    push_frame[DATA_LSB +: DATA_WIDTH]        = (mode_q == MODE_WRITE) ? data_q : '0;
    push_frame[MODE_BIT]                      = mode_q;
  end

  // ---------------- datapath ----------------
  // Address and data shift in from the top, so after exactly ADDR_WIDTH
  // (DATA_WIDTH) shifts the first serial bit sits at bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sready_q <= 1'b0;
      mode_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      sready_q <= sready_d;
      case (state_q)
        ST_IDLE: begin
          if (mvalid && sready_q) begin
            mode_q <= smode;
            addr_q <= {swdata, addr_q[ADDR_WIDTH-1:1]};
            cnt_q  <= CNT_W'(1);
          end
        end
        ST_ADDR: begin
          if (mvalid) begin
            addr_q <= {swdata, addr_q[ADDR_WIDTH-1:1]};
            cnt_q  <= addr_last ? '0 : cnt_q + CNT_W'(1);
          end
        end
        ST_WDATA: begin
          if (mvalid) begin
            data_q <= {swdata, data_q[DATA_WIDTH-1:1]};
            cnt_q  <= data_last ? '0 : cnt_q + CNT_W'(1);
          end
        end
        ST_SPLIT: begin
          if (rx_valid)         rdata_q <= rx_data;
          else if (timeout_hit) rdata_q <= '1;
        end
        ST_RDATA: begin
          rdata_q <= {1'b0, rdata_q[DATA_WIDTH-1:1]};
          cnt_q   <= data_last ? '0 : cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef BRIDGE_RD_TIMEOUT_EN
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  logic [TW-1:0] tcnt_q;

  // Counts cycles spent in SPLIT; FSM leaves SPLIT before it can wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      tcnt_q <= '0;
    else if (state_q == ST_SPLIT) tcnt_q <= tcnt_q + TW'(1);
    else                          tcnt_q <= '0;
  end

  assign timeout_hit = (state_q == ST_SPLIT) && !rx_valid && (tcnt_q == TW'(RD_TIMEOUT - 1));
  assign rd_timeout  = timeout_hit;
`else
  assign timeout_hit = 1'b0;
`endif

  // ---------------- request queue ----------------
  bus_bridge_fifo #(
    .WIDTH (FRAME_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (push_frame),
    .pop_i   (pop),
    .rdata_o (tx_frame),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign tx_valid = !fifo_empty;

  // Space is reserved when a transaction is accepted in IDLE.
  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

endmodule

// File: tb/tb_bus_bridge_slave_q.sv
// tb/tb_bus_bridge_slave_q.sv - self-checking bench for bus_bridge_slave_q
module tb_bus_bridge_slave_q;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int FW = AW + DW + 1;

  logic          clk;
  logic          rst;
  logic          swdata;
  logic          smode;
  logic          mvalid;
  logic          split_grant;
  logic          srdata;
  logic          svalid;
  logic          sready;
  logic          ssplit;
  logic [FW-1:0] tx_frame;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic [2:0]    fifo_count;
`ifdef BRIDGE_RD_TIMEOUT_EN
  logic          rd_timeout;
`endif

  int total = 0;
  int bad   = 0;

  logic [FW-1:0] exp_q[$];
  logic [DW-1:0] rd_exp_q[$];

  bus_bridge_slave_q #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (4)
`ifdef BRIDGE_RD_TIMEOUT_EN
    ,
    .RD_TIMEOUT (50)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .swdata      (swdata),
    .smode       (smode),
    .mvalid      (mvalid),
    .split_grant (split_grant),
    .srdata      (srdata),
    .svalid      (svalid),
    .sready      (sready),
    .ssplit      (ssplit),
    .tx_frame    (tx_frame),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
`ifdef BRIDGE_RD_TIMEOUT_EN
    .rd_timeout  (rd_timeout),
`endif
    .fifo_count  (fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  // Drives one transaction starting at the current negedge; returns at the
  // negedge of the PUSH cycle with mvalid dropped.
  task automatic send_txn(input logic mode, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    for (int i = 0; i < AW; i++) begin
      mvalid = 1'b1; smode = mode; swdata = addr[i];
      @(negedge clk);
    end
    if (mode) begin
      for (int i = 0; i < DW; i++) begin
        mvalid = 1'b1; swdata = data[i];
        @(negedge clk);
      end
    end
    mvalid = 1'b0; swdata = 1'b0; smode = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; swdata = 0; smode = 0; mvalid = 0; split_grant = 0;
    tx_ready = 0; rx_data = '0; rx_valid = 0;
    repeat (3) @(negedge clk);
    total++; if (sready !== 1'b0) begin bad++; $display("FAIL rst_sready: got %0b want 0", sready); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid: got %0b want 0", tx_valid); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
    total++; if ({ssplit, svalid, srdata} !== 3'b000) begin bad++; $display("FAIL rst_serial: got %b want 000", {ssplit, svalid, srdata}); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (sready !== 1'b1) begin bad++; $display("FAIL rst_release_sready: got %0b want 1", sready); end
  endtask

  task automatic test_write();
    logic [FW-1:0] exp;
    tx_ready = 1'b1;
    exp_q.push_back({1'b1, 8'hD5, 12'h9AA});
    send_txn(1'b1, 12'h9AA, 8'hD5);
    total++; if (sready !== 1'b0) begin bad++; $display("FAIL wr_push_sready: got %0b want 0", sready); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL wr_early_valid: got %0b want 0", tx_valid); end
    @(negedge clk);
    exp = exp_q.pop_front();
    total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL wr_valid: got %0b want 1", tx_valid); end
    total++; if (tx_frame !== exp) begin bad++; $display("FAIL wr_frame: got %h want %h", tx_frame, exp); end
    total++; if (sready !== 1'b1) begin bad++; $display("FAIL wr_sready_back: got %0b want 1", sready); end
    @(negedge clk);
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL wr_valid_once: got %0b want 0", tx_valid); end
  endtask

  task automatic test_read();
    logic [FW-1:0] exp;
    logic [DW-1:0] got, rexp;
    logic [DW-1:0] sv;
    tx_ready = 1'b1;
    exp_q.push_back({1'b0, 8'h00, 12'h9AA});
    send_txn(1'b0, 12'h9AA, 8'h00);
    total++; if (sready !== 1'b0) begin bad++; $display("FAIL rd_push_sready: got %0b want 0", sready); end
    @(negedge clk);
    exp = exp_q.pop_front();
    total++; if (tx_valid !== 1'b1 || tx_frame !== exp) begin bad++; $display("FAIL rd_frame: got %0b/%h want 1/%h", tx_valid, tx_frame, exp); end
    total++; if (ssplit !== 1'b1) begin bad++; $display("FAIL rd_ssplit: got %0b want 1", ssplit); end
    @(negedge clk);
    total++; if (ssplit !== 1'b1 || sready !== 1'b0) begin bad++; $display("FAIL rd_split_hold: got ssplit=%0b sready=%0b want 1/0", ssplit, sready); end
    rx_data = 8'hD4; rx_valid = 1'b1;
    rd_exp_q.push_back(8'hD4);
    @(negedge clk);
    rx_valid = 1'b0;
    total++; if (ssplit !== 1'b0) begin bad++; $display("FAIL rd_ssplit_drop: got %0b want 0", ssplit); end
    rx_data = 8'h3C; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    total++; if (svalid !== 1'b0) begin bad++; $display("FAIL rd_grant_wait: got %0b want 0", svalid); end
    split_grant = 1'b1;
    @(negedge clk);
    split_grant = 1'b0;
    for (int i = 0; i < DW; i++) begin
      got[i] = srdata; sv[i] = svalid;
      @(negedge clk);
    end
    rexp = rd_exp_q.pop_front();
    total++; if (sv !== 8'hFF) begin bad++; $display("FAIL rd_svalid: got %b want 11111111", sv); end
    total++; if (got !== rexp) begin bad++; $display("FAIL rd_data: got %h want %h", got, rexp); end
    total++; if (svalid !== 1'b0 || sready !== 1'b1) begin bad++; $display("FAIL rd_done: got svalid=%0b sready=%0b want 0/1", svalid, sready); end
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] exp;
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      a = AW'(12'h123 + i * 12'h211);
      d = DW'(8'h41 + i * 8'h17);
      total++; if (sready !== 1'b1) begin bad++; $display("FAIL bp_sready_%0d: got %0b want 1", i, sready); end
      exp_q.push_back({1'b1, d, a});
      send_txn(1'b1, a, d);
      @(negedge clk);
    end
    total++; if (fifo_count !== 3'd4 || sready !== 1'b0) begin bad++; $display("FAIL bp_full: got count=%0d sready=%0b want 4/0", fifo_count, sready); end
    mvalid = 1'b1; swdata = 1'b1; smode = 1'b1;
    repeat (2) @(negedge clk);
    mvalid = 1'b0; swdata = 1'b0; smode = 1'b0;
    total++; if (fifo_count !== 3'd4 || sready !== 1'b0) begin bad++; $display("FAIL bp_blocked: got count=%0d sready=%0b want 4/0", fifo_count, sready); end
    tx_ready = 1'b1;
    exp = exp_q.pop_front();
    total++; if (tx_frame !== exp) begin bad++; $display("FAIL bp_pop0: got %h want %h", tx_frame, exp); end
    @(negedge clk);
    tx_ready = 1'b0;
    total++; if (fifo_count !== 3'd3 || sready !== 1'b1) begin bad++; $display("FAIL bp_one_pop: got count=%0d sready=%0b want 3/1", fifo_count, sready); end
    tx_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      exp = exp_q.pop_front();
      total++; if (tx_valid !== 1'b1 || tx_frame !== exp) begin bad++; $display("FAIL bp_pop%0d: got %0b/%h want 1/%h", i, tx_valid, tx_frame, exp); end
      @(negedge clk);
    end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL bp_drained: got %0d want 0", fifo_count); end
  endtask

  task automatic test_push_pop();
    logic [FW-1:0] exp;
    tx_ready = 1'b0;
    exp_q.push_back({1'b1, 8'hA1, 12'h0F0}); send_txn(1'b1, 12'h0F0, 8'hA1); @(negedge clk);
    exp_q.push_back({1'b1, 8'hB2, 12'hF0F}); send_txn(1'b1, 12'hF0F, 8'hB2); @(negedge clk);
    exp_q.push_back({1'b1, 8'hC3, 12'h555}); send_txn(1'b1, 12'h555, 8'hC3);
    total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL pp_pre: got %0d want 2", fifo_count); end
    tx_ready = 1'b1;
    exp = exp_q.pop_front();
    total++; if (tx_frame !== exp) begin bad++; $display("FAIL pp_head: got %h want %h", tx_frame, exp); end
    @(negedge clk);
    tx_ready = 1'b0;
    total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL pp_count: got %0d want 2", fifo_count); end
    tx_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp = exp_q.pop_front();
      total++; if (tx_valid !== 1'b1 || tx_frame !== exp) begin bad++; $display("FAIL pp_order%0d: got %0b/%h want 1/%h", i, tx_valid, tx_frame, exp); end
      @(negedge clk);
    end
    total++; if (fifo_count !== 3'd0 || tx_valid !== 1'b0) begin bad++; $display("FAIL pp_drained: got %0d/%0b want 0/0", fifo_count, tx_valid); end
  endtask

  task automatic test_reset_midwrite();
    logic [FW-1:0] exp;
    logic [AW-1:0] pa;
    tx_ready = 1'b0;
    exp_q.push_back({1'b1, 8'h77, 12'h321}); send_txn(1'b1, 12'h321, 8'h77); @(negedge clk);
    pa = 12'hFFF;
    for (int i = 0; i < 5; i++) begin
      mvalid = 1'b1; smode = 1'b1; swdata = pa[i];
      @(negedge clk);
    end
    mvalid = 1'b0; swdata = 1'b0; smode = 1'b0;
    rst = 1'b1;
    #1;
    exp_q.delete();
    total++; if ({sready, ssplit, svalid, srdata, tx_valid} !== 5'b0) begin bad++; $display("FAIL mid_rst_out: got %b want 00000", {sready, ssplit, svalid, srdata, tx_valid}); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL mid_rst_count: got %0d want 0", fifo_count); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tx_ready = 1'b1;
    exp_q.push_back({1'b1, 8'h3C, 12'h5A3});
    send_txn(1'b1, 12'h5A3, 8'h3C);
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL mid_early: got %0b want 0", tx_valid); end
    @(negedge clk);
    exp = exp_q.pop_front();
    total++; if (tx_valid !== 1'b1 || tx_frame !== exp) begin bad++; $display("FAIL mid_frame: got %0b/%h want 1/%h", tx_valid, tx_frame, exp); end
    @(negedge clk);
  endtask

`ifdef BRIDGE_RD_TIMEOUT_EN
  task automatic test_timeout();
    logic [FW-1:0] exp;
    logic [DW-1:0] got, rexp;
    int n;
    tx_ready = 1'b1;
    exp_q.push_back({1'b0, 8'h00, 12'h1B4});
    rd_exp_q.push_back(8'hFF);
    send_txn(1'b0, 12'h1B4, 8'h00);
    @(negedge clk);
    exp = exp_q.pop_front();
    total++; if (tx_frame !== exp) begin bad++; $display("FAIL to_frame: got %h want %h", tx_frame, exp); end
    n = 1;
    while (rd_timeout !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++; if (n !== 50) begin bad++; $display("FAIL to_cycle: got %0d want 50", n); end
    @(negedge clk);
    total++; if (ssplit !== 1'b0 || rd_timeout !== 1'b0) begin bad++; $display("FAIL to_exit: got ssplit=%0b pulse=%0b want 0/0", ssplit, rd_timeout); end
    rx_data = 8'h00; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; split_grant = 1'b1;
    @(negedge clk);
    split_grant = 1'b0;
    for (int i = 0; i < DW; i++) begin
      got[i] = srdata;
      @(negedge clk);
    end
    rexp = rd_exp_q.pop_front();
    total++; if (got !== rexp) begin bad++; $display("FAIL to_data: got %h want %h", got, rexp); end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_push_pop();
    test_reset_midwrite();
`ifdef BRIDGE_RD_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
